// File: rtl/muldiv_defs.sv
// ============================================================================
//  Module      : muldiv_defs (package)
//  Description : Shared RV32M funct3 op codes, FSM state encodings and
//                operand-signedness helpers for the iterative mul/div unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_defs;

    // RV32M funct3 encodings
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // FSM state encodings
    localparam int         ST_W     = 2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_FIXUP = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // rs1 is treated as two's complement for every signed op including MULHSU
    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is unsigned for MULHSU and for all *U ops
    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_iter_core.sv
// ============================================================================
//  Module      : muldiv_iter_core
//  Description : One-step-per-enable datapath over a 2*XLEN working register.
//                mode=0: shift-add multiply, acc ends as {hi,lo} product.
//                mode=1: restoring divide, acc ends as {remainder,quotient}.
//                Operands are unsigned magnitudes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic            i_mode,
    input  logic            i_init,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_acc_hi,
    output logic [XLEN-1:0] o_acc_lo
);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;   // multiplicand (mul) or divisor (div)

    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_div_shift;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_div_diff;
    logic [2*XLEN-1:0] w_div_next;

    // Next-step values for both modes; the multiplier sits in the low half
    // and is consumed LSB first, the dividend is shifted out MSB first.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                      (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
        w_mul_next  = {w_mul_sum, r_acc[XLEN-1:1]};
        w_div_shift = r_acc[2*XLEN-1:XLEN-1];
        w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
        // Partial remainder stays below the divisor, so the difference fits
        w_div_diff  = w_div_shift[XLEN-1:0] - r_opnd;
        w_div_next  = {(w_div_ge ? w_div_diff : w_div_shift[XLEN-1:0]),
                       r_acc[XLEN-2:0], w_div_ge};
    end

    // Working register: load on init, one iteration per enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_opnd <= '0;
        end else if (i_init) begin
            r_acc  <= i_mode ? {{XLEN{1'b0}}, i_a} : {{XLEN{1'b0}}, i_b};
            r_opnd <= i_mode ? i_b : i_a;
        end else if (i_en) begin
            r_acc  <= i_mode ? w_div_next : w_mul_next;
        end
    end

    assign o_acc_hi = r_acc[2*XLEN-1:XLEN];
    assign o_acc_lo = r_acc[XLEN-1:0];

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative RV32M multiply/divide unit. 32 CALC iterations,
//                one FIXUP for sign/select, then a registered done pulse with
//                the writeback result, destination and write enable.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit
    import muldiv_defs::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            wen_out
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  c_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  c_ALL_ONES = {XLEN{1'b1}};

    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_f3;
    logic [XLEN-1:0]  r_a;
    logic [XLEN-1:0]  r_b;
    logic [4:0]       r_rd;
    logic             r_special;
    logic             r_neg;
    logic [XLEN-1:0]  r_result;
    logic [4:0]       r_rd_out;
    logic             r_done;

    logic             w_accept;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [XLEN-1:0]  w_a_mag;
    logic [XLEN-1:0]  w_b_mag;
    logic             w_special;
    logic             w_neg;
    logic             w_core_en;
    logic             w_core_init;
    logic             w_core_mode;
    logic             w_load_result;
    logic [XLEN-1:0]  w_acc_hi;
    logic [XLEN-1:0]  w_acc_lo;
    logic [2*XLEN-1:0] w_prod_adj;
    logic [XLEN-1:0]  w_quo_adj;
    logic [XLEN-1:0]  w_rem_adj;
    logic [XLEN-1:0]  w_fix_result;

    // Request decode: accept only in IDLE and not while the done pulse is out
    // (the core re-issues a start that collides with done).
    always_comb begin
        w_accept  = (r_state == ST_IDLE) && start && !r_done;
        w_a_neg   = a_is_signed(funct3) && op_a[XLEN-1];
        w_b_neg   = b_is_signed(funct3) && op_b[XLEN-1];
        w_a_mag   = w_a_neg ? -op_a : op_a;
        w_b_mag   = w_b_neg ? -op_b : op_b;
        w_special = funct3[2] &&
                    ((op_b == '0) ||
                     (((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                      (op_a == c_INT_MIN) && (op_b == c_ALL_ONES)));
        // REM takes the dividend's sign; everything else the XOR of the
        // effective signs (unsigned operands contribute zero).
        w_neg     = (funct3 == F3_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next_state = w_special ? ST_FIXUP : ST_CALC;
            ST_CALC:  if (r_cnt == c_CNT_LAST) w_next_state = ST_FIXUP;
            ST_FIXUP: w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Outputs and datapath controls decoded from state
    always_comb begin
        w_core_en     = (r_state == ST_CALC);
        w_core_init   = w_accept && !w_special;
        w_core_mode   = (r_state == ST_IDLE) ? funct3[2] : r_f3[2];
        w_load_result = (r_state == ST_FIXUP);
        busy          = (r_state != ST_IDLE) || r_done;
        done          = r_done;
        wen_out       = r_done && (r_rd_out != 5'd0);
        result        = r_result;
        rd_out        = r_rd_out;
    end

    muldiv_iter_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk      (clock),
        .rst      (reset),
        .i_en     (w_core_en),
        .i_mode   (w_core_mode),
        .i_init   (w_core_init),
        .i_a      (w_a_mag),
        .i_b      (w_b_mag),
        .o_acc_hi (w_acc_hi),
        .o_acc_lo (w_acc_lo)
    );

    // Sign correction and result selection for the FIXUP cycle
    always_comb begin
        w_prod_adj = r_neg ? -{w_acc_hi, w_acc_lo} : {w_acc_hi, w_acc_lo};
        w_quo_adj  = r_neg ? -w_acc_lo : w_acc_lo;
        w_rem_adj  = r_neg ? -w_acc_hi : w_acc_hi;
        if (r_special) begin
            // funct3[1] separates REM/REMU from DIV/DIVU
            if (r_b == '0) w_fix_result = r_f3[1] ? r_a : c_ALL_ONES;
            else           w_fix_result = r_f3[1] ? '0  : c_INT_MIN;
        end else begin
            case (r_f3)
                F3_MUL:                       w_fix_result = w_prod_adj[XLEN-1:0];
                F3_MULH, F3_MULHSU, F3_MULHU: w_fix_result = w_prod_adj[2*XLEN-1:XLEN];
                F3_DIV, F3_DIVU:              w_fix_result = w_quo_adj;
                default:                      w_fix_result = w_rem_adj;
            endcase
        end
    end

    // Request latch, iteration counter, output registers and done pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_f3      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_rd      <= '0;
            r_special <= 1'b0;
            r_neg     <= 1'b0;
            r_result  <= '0;
            r_rd_out  <= '0;
            r_done    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt     <= '0;
                r_f3      <= funct3;
                r_a       <= op_a;
                r_b       <= op_b;
                r_rd      <= rd_in;
                r_special <= w_special;
                r_neg     <= w_neg;
            end else if (w_core_en) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_load_result) begin
                r_result <= w_fix_result;
                r_rd_out <= r_rd;
            end
            r_done <= (r_state == ST_DONE);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Directed self-checking bench for muldiv_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        wen_out;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(
        .XLEN  (32),
        .CNT_W (5)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .funct3  (funct3),
        .op_a    (op_a),
        .op_b    (op_b),
        .rd_in   (rd_in),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .rd_out  (rd_out),
        .wen_out (wen_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait (bounded) for done; check latency and outputs
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_res, input int exp_lat, input logic exp_wen);
        int n;
        @(posedge clock); #1;
        start = 1'b1; funct3 = f3; op_a = a; op_b = b; rd_in = rd;
        @(posedge clock); #1;               // sampling edge
        start = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; rd_in = 5'd31;
        n = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clock); #1;
            if (done) begin n = k; break; end
        end
        chk_eq({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk_eq({tag, "_res"}, result, exp_res);
        chk_eq({tag, "_rd"}, {27'd0, rd_out}, {27'd0, rd});
        chk_eq({tag, "_wen"}, {31'd0, wen_out}, {31'd0, exp_wen});
    endtask

    initial begin
        int pulses;
        int busy_drop;
        int lat;
        logic [31:0] first_res;

        reset = 1'b1; start = 1'b0; funct3 = 3'd0;
        op_a = '0; op_b = '0; rd_in = '0;
        repeat (2) @(posedge clock);
        #1;
        chk_eq("rst_busy", {31'd0, busy}, 32'd0);
        chk_eq("rst_done", {31'd0, done}, 32'd0);
        chk_eq("rst_wen", {31'd0, wen_out}, 32'd0);
        chk_eq("rst_result", result, 32'd0);
        chk_eq("rst_rd", {27'd0, rd_out}, 32'd0);
        reset = 1'b0;

        // Normal operations: 34-edge latency
        do_op("mul",    3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34, 1'b1);
        do_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 34, 1'b1);
        do_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 34, 1'b1);
        do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 34, 1'b1);
        do_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 34, 1'b1);
        do_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 34, 1'b1);
        do_op("divu",   3'b101, 32'd100,       32'd7,         5'd11, 32'd14,        34, 1'b1);
        do_op("remu",   3'b111, 32'd100,       32'd7,         5'd12, 32'd2,         34, 1'b1);

        // Special cases: 2-edge latency
        do_op("divu0",  3'b101, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 2, 1'b1);
        do_op("remu0",  3'b111, 32'd5,         32'd0,         5'd14, 32'd5,         2, 1'b1);
        do_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0,         2, 1'b1);
        do_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 2, 1'b1);

        // Start pulses during a running MUL must be ignored
        @(posedge clock); #1;
        start = 1'b1; funct3 = 3'b000; op_a = 32'd6; op_b = 32'd7; rd_in = 5'd9;
        @(posedge clock); #1;
        start = 1'b0;
        pulses = 0; busy_drop = 0; lat = 0; first_res = '0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clock); #1;
            if (done) begin
                pulses++;
                if (pulses == 1) begin lat = k; first_res = result; end
            end else if (pulses == 0 && !busy) begin
                busy_drop++;
            end
            if (k == 3 || k == 20) begin
                start = 1'b1; op_a = 32'd100; op_b = 32'd100; rd_in = 5'd3;
            end else begin
                start = 1'b0;
            end
        end
        chk_eq("ign_pulses", 32'(pulses), 32'd1);
        chk_eq("ign_lat", 32'(lat), 32'd34);
        chk_eq("ign_res", first_res, 32'd42);
        chk_eq("ign_busy_drop", 32'(busy_drop), 32'd0);

        // Asynchronous reset in CALC aborts the operation
        @(posedge clock); #1;
        start = 1'b1; funct3 = 3'b000; op_a = 32'd11; op_b = 32'd13; rd_in = 5'd4;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk_eq("arst_busy", {31'd0, busy}, 32'd0);
        chk_eq("arst_result", result, 32'd0);
        chk_eq("arst_done", {31'd0, done}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (done) pulses++;
        end
        chk_eq("arst_no_done", 32'(pulses), 32'd0);

        // New operation after reset, destination x0: done without write enable
        do_op("mul_x0", 3'b000, 32'd3, 32'd4, 5'd0, 32'd12, 34, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
